// File: rtl/gfx_vga_out.sv
// VGA raster generator fed by an rgb30 SOP/EOP pixel stream through a small FIFO.
// Each stream frame is locked to raster (0,0); underflow or framing errors blank until a later frame.
module gfx_vga_out #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_startofpacket,
  input  logic        in_endofpacket,
  input  logic [29:0] in_data,
  output logic [9:0]  vga_r,
  output logic [9:0]  vga_g,
  output logic [9:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_de,
  output logic        frame_start,
  output logic        underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int DW      = $clog2(CLK_DIV + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [29:0] data;
  } pix_t;

  typedef enum logic [1:0] {SEEK, ARM, RUN} state_t;

  // ---------------- pixel tick ----------------
  logic [DW-1:0] div;
  logic          tick;

  assign tick = (div == DW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div <= '0;
    else        div <= tick ? '0 : div + 1'b1;
  end

  // ---------------- raster counters ----------------
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic h_wrap, v_wrap, active, at_origin, at_end, at_last, hs_n, vs_n;

  assign h_wrap    = (h == HW'(H_TOTAL - 1));
  assign v_wrap    = (v == VW'(V_TOTAL - 1));
  assign active    = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
  assign at_origin = (h == '0) && (v == '0);
  assign at_end    = h_wrap && v_wrap;
  assign at_last   = (h == HW'(H_ACTIVE - 1)) && (v == VW'(V_ACTIVE - 1));
  assign hs_n      = !((h >= HW'(H_ACTIVE + H_FP)) && (h < HW'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs_n      = !((v >= VW'(V_ACTIVE + V_FP)) && (v < VW'(V_ACTIVE + V_FP + V_SYNC)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (tick) begin
      h <= h_wrap ? '0 : h + 1'b1;
      if (h_wrap) v <= v_wrap ? '0 : v + 1'b1;
    end
  end

  // ---------------- input FIFO ----------------
  pix_t          mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, count;
  logic          full, empty, push, pop, rdy_en;
  pix_t          head;

  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  // rdy_en keeps the stream stalled for the first cycle out of reset
  assign in_ready = rdy_en && !full;
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {in_startofpacket, in_endofpacket, in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------- frame lock FSM ----------------
  state_t      state;
  logic [29:0] rgb;

  // A stray SOP away from (0,0) is left in the FIFO so the next frame can lock on it.
  always_comb begin
    pop = 1'b0;
    case (state)
      SEEK:    pop = !empty && !head.sop;
      RUN:     pop = tick && active && !empty && !(head.sop && !at_origin);
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEEK;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_de      <= 1'b0;
      rgb         <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      frame_start <= tick && (state == RUN) && at_origin;
      if (tick) begin
        vga_hsync <= hs_n;
        vga_vsync <= vs_n;
        vga_de    <= active;
        rgb       <= ((state == RUN) && pop) ? head.data : '0;
      end
      case (state)
        SEEK: if (!empty && head.sop) state <= ARM;
        ARM:  if (tick && at_end) state <= RUN;
        RUN: begin
          if (tick && active) begin
            if (empty) begin
              underflow <= 1'b1;
              state     <= SEEK;
            end else if (head.sop && !at_origin) begin
              state <= ARM;
            end else if (at_last != head.eop) begin
              underflow <= 1'b1;
              state     <= SEEK;
            end
          end
        end
        default: state <= SEEK;
      endcase
    end
  end

  assign vga_r = rgb[29:20];
  assign vga_g = rgb[19:10];
  assign vga_b = rgb[9:0];

endmodule

// File: tb/tb_gfx_vga_out.sv
// Scoreboard bench for gfx_vga_out on a 7x6 raster (4x3 active) against a queue-based frame model.
// A second CLK_DIV=3 instance, fed endless good frames, is checked for tick-aligned updates.
module tb_gfx_vga_out;
  localparam int HA = 4, HT = 7, VA = 3, VT = 6, NPIX = HT * VT;
  localparam int SEEK_M = 0, ARM_M = 1, RUN_M = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic        in_ready;
  logic [29:0] in_data = '0;
  logic [9:0]  vga_r, vga_g, vga_b;
  logic        vga_hsync, vga_vsync, vga_de, frame_start, underflow;

  logic        in_ready3, sop3, eop3;
  logic [29:0] data3;
  logic [9:0]  r3, g3, b3;
  logic        hs3, vs3, de3, fs3, uf3;
  int          idx3;

  always #5 clk = ~clk;

  gfx_vga_out #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
                .V_SYNC(1), .V_BP(1), .CLK_DIV(1), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_data(in_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_de(vga_de), .frame_start(frame_start), .underflow(underflow));

  gfx_vga_out #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
                .V_SYNC(1), .V_BP(1), .CLK_DIV(3), .FIFO_DEPTH(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(1'b1), .in_ready(in_ready3),
    .in_startofpacket(sop3), .in_endofpacket(eop3), .in_data(data3),
    .vga_r(r3), .vga_g(g3), .vga_b(b3), .vga_hsync(hs3), .vga_vsync(vs3),
    .vga_de(de3), .frame_start(fs3), .underflow(uf3));

  typedef struct packed {
    logic        rdy;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic        uf;
    logic [29:0] rgb;
  } obs_t;

  int          vectors = 0, miscompares = 0;
  obs_t        exp_q[$];
  logic [32:0] stim_q[$];   // bit 32 marks an idle (valid=0) cycle
  logic [31:0] mq[$];       // model FIFO: {sop, eop, data}

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.rdy = in_ready;  o.hs = vga_hsync; o.vs = vga_vsync; o.de = vga_de;
    o.fs  = frame_start; o.uf = underflow; o.rgb = {vga_r, vga_g, vga_b};
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got rdy=%b hs=%b vs=%b de=%b fs=%b uf=%b rgb=%h, expected rdy=%b hs=%b vs=%b de=%b fs=%b uf=%b rgb=%h",
               name, $time, got.rdy, got.hs, got.vs, got.de, got.fs, got.uf, got.rgb,
               exp.rdy, exp.hs, exp.vs, exp.de, exp.fs, exp.uf, exp.rgb);
    end
  endtask

  // Reference model: one raster position per clk; frame lock rules applied to a word queue.
  initial begin
    int   mp, mmode, h, v;
    bit   muf, mrdy, act, pop_m, ready_pre;
    obs_t e;
    mp = 0; mmode = SEEK_M; muf = 0; mrdy = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete(); exp_q.delete();
        mp = 0; mmode = SEEK_M; muf = 0; mrdy = 0;
      end else begin
        h = mp % HT; v = mp / HT;
        act = (h < HA) && (v < VA);
        e = '0;
        e.hs = !(h >= HA + 1 && h < HA + 2);
        e.vs = !(v >= VA + 1 && v < VA + 2);
        e.de = act;
        pop_m = 0;
        ready_pre = mrdy && (mq.size() < 16);
        if (mmode == SEEK_M) begin
          if (mq.size() != 0) begin
            if (mq[0][31]) mmode = ARM_M;
            else pop_m = 1;
          end
        end else if (mmode == ARM_M) begin
          if (mp == NPIX - 1) mmode = RUN_M;
        end else begin
          e.fs = (mp == 0);
          if (act) begin
            if (mq.size() == 0) begin
              muf = 1; mmode = SEEK_M;
            end else if (mq[0][31] && mp != 0) begin
              mmode = ARM_M;
            end else begin
              pop_m = 1;
              e.rgb = mq[0][29:0];
              if ((mp == (VA - 1) * HT + HA - 1) != mq[0][30]) begin
                muf = 1; mmode = SEEK_M;
              end
            end
          end
        end
        if (pop_m) void'(mq.pop_front());
        if (in_valid && ready_pre) mq.push_back({in_sop, in_eop, in_data});
        mrdy = 1;
        e.uf = muf;
        e.rdy = mrdy && (mq.size() < 16);
        exp_q.push_back(e);
        mp = (mp + 1) % NPIX;
      end
    end
  end

  // Monitor: compares every clk after the active edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) check("reset", sample(), reset_obs());
    else if (exp_q.size() != 0) check("pixel", sample(), exp_q.pop_front());
  end

  // Stream driver: presents the head of stim_q and retires it once accepted.
  initial begin
    bit had, took;
    forever begin
      @(negedge clk); #1;
      had = (stim_q.size() != 0);
      if (had && !stim_q[0][32]) begin
        in_valid = 1'b1;
        {in_sop, in_eop, in_data} = stim_q[0][31:0];
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      took = in_valid ? (in_ready && rst_n) : 1'b1;
      if (had && took && stim_q.size() != 0) void'(stim_q.pop_front());
    end
  end

  // CLK_DIV=3 instance: endless well-formed 12-pixel frames.
  assign sop3  = (idx3 == 0);
  assign eop3  = (idx3 == 11);
  assign data3 = {10'(idx3 + 1), 10'(idx3 * 5 + 3), 10'(idx3 * 9 + 7)};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx3 <= 0;
    else if (in_ready3) idx3 <= (idx3 == 11) ? 0 : idx3 + 1;
  end

  int          k3 = 0, last_fs3 = -1, fs_cnt3 = 0;
  logic [33:0] prev3, cur3;
  logic        prev_fs3 = 1'b0;

  initial forever begin
    @(negedge clk);
    cur3 = {hs3, vs3, de3, uf3, r3, g3, b3};
    if (!rst_n) begin
      k3 = 0; last_fs3 = -1; prev_fs3 = 1'b0;
      prev3 = {2'b11, 32'd0};
    end else begin
      k3++;
      if (cur3 != prev3) begin
        vectors++;
        if (k3 % 3 != 0) begin
          miscompares++;
          $display("FAIL div3_update @%0t: output changed at edge %0d after reset, expected only on multiples of 3", $time, k3);
        end
      end
      if (fs3) begin
        vectors++;
        if (k3 % 3 != 0 || prev_fs3) begin
          miscompares++;
          $display("FAIL div3_frame_start @%0t: pulse at edge %0d (prev=%b), expected 1-clk pulse on a multiple of 3", $time, k3, prev_fs3);
        end
        if (last_fs3 >= 0) begin
          vectors++;
          if (k3 - last_fs3 != 3 * NPIX) begin
            miscompares++;
            $display("FAIL div3_frame_period @%0t: got %0d clks, expected %0d", $time, k3 - last_fs3, 3 * NPIX);
          end
        end
        last_fs3 = k3;
        fs_cnt3++;
      end
      prev3 = cur3;
      prev_fs3 = fs3;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic void push_word(input bit sop, input bit eop, input logic [29:0] d);
    stim_q.push_back({1'b0, sop, eop, d});
  endfunction

  function automatic void push_frame(input int len, input bit with_eop);
    for (int i = 0; i < len; i++)
      push_word(i == 0, with_eop && (i == len - 1), 30'($urandom));
  endfunction

  function automatic void push_gap(input int n);
    for (int i = 0; i < n; i++) stim_q.push_back({1'b1, 32'd0});
  endfunction

  task automatic release_rst();
    @(negedge clk); #3 rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_first_cycle: got %b, expected 0", in_ready);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    release_rst();
  endtask

  task automatic drain(input int bound, input int idle);
    int n;
    n = 0;
    while (stim_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (stim_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d words left, expected 0", stim_q.size());
      stim_q.delete();
    end
    repeat (idle) @(negedge clk);
  endtask

  initial begin
    int kind, len;
    repeat (2) @(negedge clk);
    release_rst();
    repeat (90) @(negedge clk);                       // idle raster, sync only

    do_reset();                                        // known frame, then a random one
    push_word(1'b1, 1'b0, 30'h3FFFFFFF);
    for (int i = 1; i <= 10; i++) push_word(1'b0, 1'b0, 30'(i));
    push_word(1'b0, 1'b1, 30'd11);
    push_frame(12, 1'b1);
    drain(2000, 100);

    do_reset();                                        // leading junk is discarded
    push_word(1'b0, 1'b0, 30'h1234567);
    push_word(1'b0, 1'b1, 30'h2345678);
    push_word(1'b0, 1'b0, 30'h3456789);
    push_frame(12, 1'b1);
    drain(2000, 100);

    do_reset();                                        // short frame underflows, next one recovers
    push_frame(5, 1'b0);
    push_gap(120);
    push_frame(12, 1'b1);
    drain(2000, 100);

    do_reset();                                        // backpressure, then reset mid-stream
    repeat (4) push_frame(12, 1'b1);
    repeat (100) @(negedge clk);
    do_reset();
    drain(3000, 60);

    do_reset();                                        // SOP arriving at pixel 7
    push_frame(7, 1'b0);
    push_frame(12, 1'b1);
    push_frame(12, 1'b1);
    drain(2000, 100);

    do_reset();                                        // randomized mix
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 5);
      len  = $urandom_range(1, 11);
      case (kind)
        0, 1: push_frame(12, 1'b1);
        2:    begin push_frame(len, 1'b0); push_gap($urandom_range(0, 60)); end
        3:    for (int j = 0; j < len % 4 + 1; j++) push_word(1'b0, 1'($urandom), 30'($urandom));
        4:    push_gap($urandom_range(1, 80));
        default: begin push_frame(len, 1'b1); push_gap($urandom_range(0, 30)); end
      endcase
    end
    drain(20000, 200);

    vectors++;
    if (fs_cnt3 == 0) begin
      miscompares++;
      $display("FAIL div3_frames: got %0d frame_start pulses, expected at least 1", fs_cnt3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
